// File: rtl/altmem_bus_ctrl_68k.sv
// -----------------------------------------------------------------------------
// altmem_bus_ctrl_68k
//
// 68000 bus-cycle controller for the booster's alt-RAM / alt-ROM windows.
// Runs entirely on CLKOSC. A CPU cycle is detected on the synchronised falling
// edge of AS, the latched address is decoded against the control-register
// page, the enabled RAM windows and the ROM remap window, and a claimed cycle
// is sequenced through memory request, programmable wait states, DTACK and
// active DTACK negation. A memory access that never completes is aborted with
// a one-cycle bus-error request.
//
// Ports
//   CLKOSC     in   sole clock
//   RST        in   asynchronous reset, active-high
//   AS         in   CPU address strobe, active-low, asynchronous to CLKOSC
//   RW         in   1 = read, 0 = write
//   FC         in   function code, FC[2] = supervisor
//   A          in   CPU address A[23:1]
//   BGK        in   bus grant acknowledge, active-low (0 = other master)
//   MEM_READY  in   one-cycle pulse from SDRAM, data phase complete
//   MEM_REQ    out  SDRAM access request
//   SEL        out  one-hot RAM window select (0 for ROM/ctrl/foreign)
//   REMAP_A    out  A[23:20] presented to SDRAM
//   DTACK_N    out  DTACK level, active-low
//   DTACK_OE   out  DTACK output enable (0 = tristate)
//   BERR_REQ   out  one-cycle bus-error request on memory timeout
//   SLOW       out  1 = CPU clock must run from the slow source
//   WIN_EN     out  RAM window enable bits
//   ALLOWFAST  out  fast CPU clock permitted
//   ROM_EN     out  ROM remap window enabled
// -----------------------------------------------------------------------------
module altmem_bus_ctrl_68k #(
  parameter int unsigned NWIN      = 2,
  parameter logic [15:0] WIN_NIB   = 16'h0098,
  parameter logic [19:0] CTRL_BASE = 20'hFFFE0,
  parameter logic [3:0]  ROM_NIB   = 4'hE,
  parameter logic [3:0]  REMAP_NIB = 4'hB,
  parameter int unsigned WAIT_CYC  = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic            CLKOSC,
  input  logic            RST,
  input  logic            AS,
  input  logic            RW,
  input  logic [2:0]      FC,
  input  logic [23:1]     A,
  input  logic            BGK,
  input  logic            MEM_READY,
  output logic            MEM_REQ,
  output logic [NWIN-1:0] SEL,
  output logic [3:0]      REMAP_A,
  output logic            DTACK_N,
  output logic            DTACK_OE,
  output logic            BERR_REQ,
  output logic            SLOW,
  output logic [NWIN-1:0] WIN_EN,
  output logic            ALLOWFAST,
  output logic            ROM_EN
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_MEM,
    S_WAIT,
    S_CTRL,
    S_ACK,
    S_RELEASE,
    S_FOREIGN
  } state_t;

  state_t      state;

  // AS synchroniser; as_prev is the previous synchronised value for edge detect.
  logic        as_meta;
  logic        as_s;
  logic        as_prev;
  logic        as_fall;

  // Cycle attributes captured when the cycle starts.
  logic [23:1] a_lat;
  logic        rw_lat;
  logic [2:0]  fc_lat;

  logic [7:0]  tcnt;
  logic [3:0]  wait_ctr;

  logic [NWIN-1:0] win_hit;
  logic            win_any;
  logic            ctrl_hit;
  logic            rom_hit;
  logic [2:0]      ctrl_off;

  // Sync flops idle high so that leaving reset never looks like an AS fall.
  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST) begin
      as_meta <= 1'b1;
      as_s    <= 1'b1;
      as_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make the three flops shift in lockstep;
      // blocking ones would collapse the chain into a single stage.
      as_meta <= AS;
      as_s    <= as_meta;
      as_prev <= as_s;
    end
  end

  assign as_fall  = !as_s && as_prev;
  assign ctrl_hit = (a_lat[23:4] == CTRL_BASE) && fc_lat[2];
  assign rom_hit  = ROM_EN && (a_lat[23:20] == ROM_NIB);
  assign ctrl_off = a_lat[3:1];

  // Window match; scanning from the top down lets the lowest index win.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    win_hit = '0;
    win_any = 1'b0;
    for (int i = int'(NWIN) - 1; i >= 0; i--) begin
      if (WIN_EN[i] && (a_lat[23:20] == WIN_NIB[4*i +: 4])) begin
        win_hit    = '0;
        win_hit[i] = 1'b1;
        win_any    = 1'b1;
      end
    end
  end

  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      a_lat     <= '0;
      rw_lat    <= 1'b1;
      fc_lat    <= '0;
      tcnt      <= '0;
      wait_ctr  <= '0;
      MEM_REQ   <= 1'b0;
      SEL       <= '0;
      REMAP_A   <= '0;
      DTACK_N   <= 1'b1;
      DTACK_OE  <= 1'b0;
      BERR_REQ  <= 1'b0;
      SLOW      <= 1'b1;
      WIN_EN    <= '0;
      ALLOWFAST <= 1'b1;
      ROM_EN    <= 1'b0;
    end else begin
      BERR_REQ <= 1'b0;
      // Baseline slow request; the FOREIGN paths below override it.
      SLOW     <= !ALLOWFAST || !BGK;

      case (state)
        S_IDLE: begin
          if (BGK && as_fall) begin
            a_lat  <= A;
            rw_lat <= RW;
            fc_lat <= FC;
            state  <= S_DECODE;
          end
        end

        S_DECODE: begin
          tcnt    <= '0;
          SEL     <= '0;
          REMAP_A <= a_lat[23:20];
          if (ctrl_hit) begin
            state <= S_CTRL;
          end else if (win_any) begin
            SEL     <= win_hit;
            MEM_REQ <= 1'b1;
            state   <= S_MEM;
          end else if (rom_hit) begin
            REMAP_A <= REMAP_NIB;
            MEM_REQ <= 1'b1;
            state   <= S_MEM;
          end else begin
            SLOW  <= 1'b1;
            state <= S_FOREIGN;
          end
        end

        S_MEM: begin
          if (as_s) begin
            // CPU gave up the cycle: release the bus without acknowledging.
            MEM_REQ  <= 1'b0;
            DTACK_OE <= 1'b1;
            DTACK_N  <= 1'b1;
            state    <= S_RELEASE;
          end else if (MEM_READY) begin
            // Checked ahead of the timeout so a coincident ready still completes.
            MEM_REQ  <= 1'b0;
            wait_ctr <= 4'(WAIT_CYC);
            state    <= S_WAIT;
          end else begin
            tcnt <= tcnt + 8'd1;
            if (tcnt + 8'd1 == 8'(TIMEOUT)) begin
              BERR_REQ <= 1'b1;
              MEM_REQ  <= 1'b0;
              DTACK_OE <= 1'b1;
              DTACK_N  <= 1'b1;
              state    <= S_RELEASE;
            end
          end
        end

        S_WAIT: begin
          if (as_s) begin
            DTACK_OE <= 1'b1;
            DTACK_N  <= 1'b1;
            state    <= S_RELEASE;
          end else if (wait_ctr == 4'd0) begin
            DTACK_OE <= 1'b1;
            DTACK_N  <= 1'b0;
            state    <= S_ACK;
          end else begin
            wait_ctr <= wait_ctr - 4'd1;
          end
        end

        S_CTRL: begin
          if (!rw_lat) begin
            case (ctrl_off)
              3'd7: ROM_EN    <= 1'b1;
              3'd6: ALLOWFAST <= 1'b1;
              3'd5: ALLOWFAST <= 1'b0;
              default: begin
                for (int i = 0; i < int'(NWIN); i++) begin
                  if (ctrl_off == 3'(i)) WIN_EN[i] <= 1'b1;
                end
              end
            endcase
          end
          DTACK_OE <= 1'b1;
          DTACK_N  <= 1'b0;
          state    <= S_ACK;
        end

        S_ACK: begin
          if (as_s) begin
            DTACK_N <= 1'b1;
            state   <= S_RELEASE;
          end
        end

        // One cycle of driven-high DTACK before letting the line float.
        S_RELEASE: begin
          DTACK_OE <= 1'b0;
          SEL      <= '0;
          state    <= S_IDLE;
        end

        S_FOREIGN: begin
          if (as_s) state <= S_IDLE;
          else      SLOW  <= 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
